// File: rtl/par_int_host_seq_if.sv
// Command/response handshakes and host-side parallel bus pins of par_int_host_seq.
// rsp_err is present only when PAR_INT_HOST_SEQ_RDCHK_EN is defined.
interface par_int_host_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
  logic       rsp_err;
`endif
  logic       wr_done;
  logic [7:0] pi_dq_out;
  logic       pi_dq_oe;
  logic [7:0] pi_dq_in;
  logic       pi_w_r;

  modport master (
    input  cmd_valid, cmd_rd, cmd_data, rsp_ready, pi_dq_in,
    output cmd_ready, rsp_valid, rsp_data, wr_done, pi_dq_out, pi_dq_oe, pi_w_r
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
    , output rsp_err
`endif
  );

  modport slave (
    output cmd_valid, cmd_rd, cmd_data, rsp_ready, pi_dq_in,
    input  cmd_ready, rsp_valid, rsp_data, wr_done, pi_dq_out, pi_dq_oe, pi_w_r
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
    , input rsp_err
`endif
  );
endinterface

// File: rtl/par_int_host_seq.sv
// Host-side bus-cycle sequencer for the 8-bit parallel interface: timed write/read cycles.
// Define PAR_INT_HOST_SEQ_RDCHK_EN to double-sample reads and flag unstable bus data on rsp_err.
module par_int_host_seq #(
  parameter int WR_CYC  = 2,
  parameter int RD_TURN = 2
) (
  input logic                clk,
  input logic                rst,
  par_int_host_seq_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_RECOV,
    ST_RD_TURN,
    ST_RSP
  } state_t;

  if (WR_CYC < 1 || WR_CYC > 15) begin : g_bad_wr_cyc
    $error("par_int_host_seq: WR_CYC must be within 1..15");
  end
  if (RD_TURN < 1 || RD_TURN > 15) begin : g_bad_rd_turn
    $error("par_int_host_seq: RD_TURN must be within 1..15");
  end
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
  if (RD_TURN < 2) begin : g_bad_rd_chk
    $error("par_int_host_seq: read check needs RD_TURN >= 2");
  end
`endif

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       cmd_ready, accept, last_cnt, capture;
  logic       pi_w_r_q, pi_w_r_nxt;
  logic       oe_q, oe_nxt;
  logic       wr_done_q, wr_done_nxt;
  logic       rsp_valid_q, rsp_valid_nxt;
  logic [7:0] dq_out_q, dq_out_nxt;
  logic [7:0] rsp_data_q, rsp_data_nxt;
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
  logic [7:0] first_q, first_nxt;
  logic       rsp_err_q, rsp_err_nxt;
`endif

  assign cmd_ready = (state == ST_IDLE) && !rsp_valid_q;
  assign accept    = bus.cmd_valid && cmd_ready;
  assign last_cnt  = (cnt == 4'd1);
  assign capture   = (state == ST_RD_TURN) && last_cnt;

  // State, counter and every bus-facing output are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      pi_w_r_q    <= 1'b1;
      oe_q        <= 1'b0;
      wr_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      dq_out_q    <= 8'h00;
      rsp_data_q  <= 8'h00;
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
      first_q     <= 8'h00;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pi_w_r_q    <= pi_w_r_nxt;
      oe_q        <= oe_nxt;
      wr_done_q   <= wr_done_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      dq_out_q    <= dq_out_nxt;
      rsp_data_q  <= rsp_data_nxt;
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
      first_q     <= first_nxt;
      rsp_err_q   <= rsp_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bus.cmd_rd) begin
            state_nxt = ST_RD_TURN;
            cnt_nxt   = 4'(RD_TURN);
          end else begin
            state_nxt = ST_WR_SETUP;
          end
        end
      end
      ST_WR_SETUP: begin
        state_nxt = ST_WR_STROBE;
        cnt_nxt   = 4'(WR_CYC);
      end
      ST_WR_STROBE: begin
        cnt_nxt = cnt - 4'd1;
        if (last_cnt) state_nxt = ST_WR_RECOV;
      end
      ST_WR_RECOV: state_nxt = ST_IDLE;
      ST_RD_TURN: begin
        cnt_nxt = cnt - 4'd1;
        if (last_cnt) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs follow the state being entered, so oe rises one cycle before the strobe and falls one after.
  always_comb begin
    pi_w_r_nxt    = (state_nxt != ST_WR_STROBE);
    oe_nxt        = state_nxt inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_RECOV};
    wr_done_nxt   = (state_nxt == ST_WR_RECOV);
    rsp_valid_nxt = (state_nxt == ST_RSP);
    dq_out_nxt    = dq_out_q;
    if ((state == ST_IDLE) && (state_nxt == ST_WR_SETUP)) dq_out_nxt = bus.cmd_data;
    rsp_data_nxt  = rsp_data_q;
    if (capture) rsp_data_nxt = bus.pi_dq_in;
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
    first_nxt = first_q;
    if ((state == ST_RD_TURN) && (cnt == 4'd2)) first_nxt = bus.pi_dq_in;
    rsp_err_nxt = rsp_err_q && (state_nxt == ST_RSP);
    if (capture) rsp_err_nxt = (first_q != bus.pi_dq_in);
`endif
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.pi_w_r    = pi_w_r_q;
  assign bus.pi_dq_oe  = oe_q;
  assign bus.pi_dq_out = dq_out_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
  assign bus.rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_par_int_host_seq.sv
// Testbench for par_int_host_seq: directed and random command traffic checked each cycle
// against a cycle-timeline model built from the write/read latency rules.
module tb_par_int_host_seq;
  localparam int WR_CYC  = 2;
  localparam int RD_TURN = 2;
  localparam int MAXC    = 8192;
  localparam int BIG     = 1 << 30;
  localparam int N_RAND  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  par_int_host_seq_if bus_if();

  par_int_host_seq #(.WR_CYC(WR_CYC), .RD_TURN(RD_TURN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: per-cycle expectations for bus pins plus the pending response.
  int         cyc           = 0;
  int         ready_at      = 0;
  int         rd_sample_cyc = -1;
  int         accepted      = 0;
  bit         exp_low  [MAXC];
  bit         exp_oe   [MAXC];
  bit         exp_done [MAXC];
  logic [7:0] hist     [MAXC];
  logic [7:0] exp_out    = 8'h00;
  logic [7:0] exp_rdata  = 8'h00;
  bit         exp_rvalid = 1'b0;
  bit         exp_rerr   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  task automatic checkModel();
    checkOutput("cmd_ready", 32'(bus_if.cmd_ready), 32'(cyc >= ready_at));
    checkOutput("pi_w_r", 32'(bus_if.pi_w_r), 32'(!exp_low[cyc]));
    checkOutput("pi_dq_oe", 32'(bus_if.pi_dq_oe), 32'(exp_oe[cyc]));
    checkOutput("wr_done", 32'(bus_if.wr_done), 32'(exp_done[cyc]));
    checkOutput("pi_dq_out", 32'(bus_if.pi_dq_out), 32'(exp_out));
    checkOutput("rsp_valid", 32'(bus_if.rsp_valid), 32'(exp_rvalid));
    if (exp_rvalid) checkOutput("rsp_data", 32'(bus_if.rsp_data), 32'(exp_rdata));
`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
    checkOutput("rsp_err", 32'(bus_if.rsp_err), 32'(exp_rvalid && exp_rerr));
`endif
    checkOutput("no_contend", 32'(bus_if.pi_w_r | bus_if.pi_dq_oe), 32'd1);
  endtask

  task automatic modelReset();
    exp_rvalid    = 1'b0;
    exp_rerr      = 1'b0;
    rd_sample_cyc = -1;
    exp_out       = 8'h00;
    ready_at      = cyc + 1;
    for (int i = cyc + 1; i < MAXC; i++) begin
      exp_low[i]  = 1'b0;
      exp_oe[i]   = 1'b0;
      exp_done[i] = 1'b0;
    end
  endtask

  // One clock cycle: check outputs, drive this cycle's inputs, then advance the model.
  task automatic applyStimulus(input bit rst_v, input bit cv, input bit rd,
                               input logic [7:0] data, input bit rr, input logic [7:0] din);
    bit ready_c;
    @(negedge clk);
    checkModel();
    if (rst_v && !rst) begin
      rst = 1'b1;
      #1;
      checkOutput("rst_pi_w_r", 32'(bus_if.pi_w_r), 32'd1);
      checkOutput("rst_oe", 32'(bus_if.pi_dq_oe), 32'd0);
      checkOutput("rst_wr_done", 32'(bus_if.wr_done), 32'd0);
    end
    rst                = rst_v;
    bus_if.cmd_valid   = cv && !rst_v;
    bus_if.cmd_rd      = rd;
    bus_if.cmd_data    = data;
    bus_if.rsp_ready   = rr;
    bus_if.pi_dq_in    = din;
    hist[cyc]          = din;
    ready_c            = (cyc >= ready_at);
    if (rst_v) begin
      modelReset();
    end else begin
      if (exp_rvalid && rr) begin
        exp_rvalid = 1'b0;
        exp_rerr   = 1'b0;
        ready_at   = cyc + 1;
      end
      if (rd_sample_cyc == cyc) begin
        exp_rvalid    = 1'b1;
        exp_rdata     = din;
        exp_rerr      = (hist[cyc-1] != din);
        rd_sample_cyc = -1;
      end
      if (ready_c && cv) begin
        accepted++;
        if (rd) begin
          rd_sample_cyc = cyc + RD_TURN;
          ready_at      = BIG;
        end else begin
          exp_out = data;
          for (int k = cyc + 1; k <= cyc + 2 + WR_CYC; k++) exp_oe[k] = 1'b1;
          for (int k = cyc + 2; k <= cyc + 1 + WR_CYC; k++) exp_low[k] = 1'b1;
          exp_done[cyc + 2 + WR_CYC] = 1'b1;
          ready_at = cyc + 3 + WR_CYC;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int target;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_rd    = 1'b0;
    bus_if.cmd_data  = 8'h00;
    bus_if.rsp_ready = 1'b0;
    bus_if.pi_dq_in  = 8'h00;

    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00);
    checkOutput("rst_rsp_data", 32'(bus_if.rsp_data), 32'h0);

    // Single write of A5, released from reset in the accept cycle.
    applyStimulus(0, 1, 0, 8'hA5, 0, 8'h00);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);

    // Read of 3C, response held off for 5 cycles while a write waits.
    applyStimulus(0, 1, 1, 8'hEE, 0, 8'h3C);
    for (int i = 0; i < RD_TURN; i++) applyStimulus(0, 0, 0, 8'h00, 0, 8'h3C);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'h5A, 0, 8'h99);
    applyStimulus(0, 1, 0, 8'h5A, 1, 8'h99);
    applyStimulus(0, 1, 0, 8'h5A, 0, 8'h99);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);

    // Reset in the middle of the write strobe.
    applyStimulus(0, 1, 0, 8'hC3, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);

`ifdef PAR_INT_HOST_SEQ_RDCHK_EN
    // Bus moves from 11 to 22 between the two samples, then a stable read.
    applyStimulus(0, 1, 1, 8'h00, 0, 8'h11);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h11);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h22);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'h22);
    applyStimulus(0, 1, 1, 8'h00, 0, 8'h77);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h77);
    applyStimulus(0, 0, 0, 8'h00, 0, 8'h77);
    applyStimulus(0, 0, 0, 8'h00, 1, 8'h77);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
`endif

    // Random mix of reads and writes with random request and response gaps.
    target = accepted + N_RAND;
    for (int n = 0; n < 6000 && accepted < target; n++) begin
      applyStimulus(0, ($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 99) < 60), 8'($urandom));
    end
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 8'h00, 1, 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/par_int_host_seq.md
Name: par_int_host_seq

Overview:
- Host-side bus-cycle sequencer that drives the 8-bit parallel interface.
- Turns single-byte command requests (valid/ready) into timed write and read cycles on the interface data bus and its write/read select line.
- On reads, samples the returned byte and presents it on a response channel.
- Guarantees no bus contention: it only drives the bus when the interface is not driving it.

Parameters:
- WR_CYC, 2, number of cycles pi_w_r is held low during a write strobe (legal 1..15)
- RD_TURN, 2, turnaround/settle cycles from bus release to read sample (legal 1..15)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block can accept a command this cycle
- cmd_rd  input  1  1 = read cycle, 0 = write cycle
- cmd_data  input  8  write byte (ignored for reads)
- rsp_valid  output  1  read byte available
- rsp_ready  input  1  consumer accepts read byte
- rsp_data  output  8  sampled read byte
- wr_done  output  1  one-cycle pulse when a write cycle completes
- pi_dq_out  output  8  byte driven toward the interface bus
- pi_dq_oe  output  1  host bus-driver enable (tristate control)
- pi_dq_in  input  8  bus value as seen by the host
- pi_w_r  output  1  interface select: 0 = host writes, 1 = interface drives/read

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, pi_w_r=1, pi_dq_oe=0, pi_dq_out=8'h00.
  - rsp_valid=0, rsp_data=8'h00, wr_done=0, counter=0.
  - A mid-cycle reset aborts the cycle with no response and no wr_done.
- Invariants:
  - pi_w_r=0 implies pi_dq_oe=1.
  - pi_dq_oe changes only while pi_w_r=1.
  - pi_dq_out changes only in IDLE→WR_SETUP.
- cmd_ready:
  - Asserted (combinational) only when state=IDLE and rsp_valid=0.
  - Accept = cmd_valid & cmd_ready at a rising edge; call that edge cycle T.
- FSM states, all outputs registered:
  - IDLE: pi_w_r=1, pi_dq_oe=0. On a write accept, latch cmd_data into pi_dq_out → WR_SETUP. On a read accept → RD_TURN with counter=RD_TURN.
  - WR_SETUP (1 cycle, T+1): pi_dq_oe=1, pi_w_r=1. Data is set up before the strobe. → WR_STROBE with counter=WR_CYC.
  - WR_STROBE (WR_CYC cycles): pi_w_r=0, pi_dq_oe=1, counter decrements. At counter==1 → WR_RECOV.
  - WR_RECOV (1 cycle): pi_w_r=1, pi_dq_oe=1 (data hold), wr_done=1 for exactly this cycle. → IDLE, where oe drops.
  - RD_TURN (RD_TURN cycles): pi_w_r=1, pi_dq_oe=0, counter decrements. At counter==1, capture pi_dq_in into rsp_data, set rsp_valid=1, → RSP.
  - RSP: hold rsp_data/rsp_valid. On rsp_ready, clear rsp_valid → IDLE.
- Latency:
  - Write: pi_w_r low for cycles T+2..T+1+WR_CYC; wr_done at T+2+WR_CYC. Next accept is possible at the edge ending cycle T+3+WR_CYC, so back-to-back writes take WR_CYC+3 cycles each.
  - Read: rsp_valid first seen in cycle T+RD_TURN+1. If rsp_ready is already high, the next accept is possible in cycle T+RD_TURN+2.
- Boundaries:
  - cmd_valid while busy: held off by cmd_ready=0. cmd_data/cmd_rd are sampled only at accept.
  - rsp_ready high before rsp_valid: no effect.
  - rsp_valid is never dropped or changed without rsp_ready.
  - WR_CYC or RD_TURN outside 1..15: elaboration error (generate-time check).

Optional Feature:
- Macro: PAR_INT_HOST_SEQ_RDCHK_EN
- Enabled:
  - Adds output rsp_err (1 bit, reset 0).
  - Reads sample pi_dq_in in the last two RD_TURN cycles; RD_TURN must be ≥2, otherwise elaboration error.
  - rsp_data takes the second sample.
  - rsp_err=1 if the two samples differ. It is valid alongside rsp_valid and cleared with it.
- Disabled: no rsp_err port, single sample as described above, no extra logic.

Test Plan:
- Reset: assert rst mid-WR_STROBE (pi_w_r=0) → pi_w_r=1, pi_dq_oe=0, wr_done never pulses, cmd_ready=1 on the first cycle after release.
- Write: WR_CYC=2, write 8'hA5 → pi_dq_out=A5 with oe at T+1, pi_w_r=0 for exactly T+2..T+3, wr_done at T+4, cmd_ready high at T+5.
- Read: RD_TURN=2, bus model drives 8'h3C → rsp_valid at T+3 with rsp_data=3C, oe=0 throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read → rsp_valid/rsp_data stable, cmd_ready=0, cmd_valid ignored. A queued write starts only after rsp_ready.
- Contention check: random mix of 200 reads/writes with random cmd_valid/rsp_ready gaps → assertion that pi_w_r=0 never occurs with oe=0, oe never toggles while pi_w_r=0, and all data matches the scoreboard.
- With PAR_INT_HOST_SEQ_RDCHK_EN: bus changes from 8'h11 to 8'h22 between the two samples → rsp_data=22, rsp_err=1. Stable bus → rsp_err=0.
